// File: rtl/bp_cfg_loader_pkg.sv
// Shared types and constants for the BlackParrot runtime config loader.
// The command struct is width-parametrised, so it is declared through a macro.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

`define BP_CFG_LOADER_CMD_S_DECLARE(core_w, reg_w, data_w) \
    typedef struct packed {                                   \
        logic              w;                                 \
        logic              bcast;                             \
        logic [core_w-1:0] core;                              \
        logic [reg_w-1:0]  reg_idx;                           \
        logic [data_w-1:0] data;                              \
    } bp_cfg_loader_cmd_s;

package bp_cfg_loader_pkg;

    typedef enum logic [0:0] {
        e_ready = 1'b0,
        e_resp  = 1'b1
    } bp_cfg_loader_state_e;

    localparam int e_cfg_ctrl_reg = 0;
    localparam int cfg_freeze_bit = 0;

endpackage

// File: rtl/bp_cfg_loader_if.sv
// Command/response port of the config loader; master is the I/O complex.
// With BP_CFG_LOADER_WMASK_EN defined, a byte write-enable (cmd_mask_i) is added.
interface bp_cfg_loader_if #(
    parameter int num_core_p   = 4,
    parameter int num_reg_p    = 8,
    parameter int data_width_p = 64
);
    localparam int core_id_width_lp  = `BSG_SAFE_CLOG2(num_core_p);
    localparam int reg_addr_width_lp = `BSG_SAFE_CLOG2(num_reg_p);

    logic                         cmd_v_i;
    logic                         cmd_ready_o;
    logic                         cmd_w_i;
    logic                         cmd_bcast_i;
    logic [core_id_width_lp-1:0]  cmd_core_i;
    logic [reg_addr_width_lp-1:0] cmd_reg_i;
    logic [data_width_p-1:0]      cmd_data_i;
`ifdef BP_CFG_LOADER_WMASK_EN
    logic [data_width_p/8-1:0]    cmd_mask_i;
`endif
    logic                         resp_v_o;
    logic [data_width_p-1:0]      resp_data_o;
    logic                         resp_yumi_i;

    modport master (
        output cmd_v_i, cmd_w_i, cmd_bcast_i, cmd_core_i, cmd_reg_i, cmd_data_i, resp_yumi_i,
        input  cmd_ready_o, resp_v_o, resp_data_o
`ifdef BP_CFG_LOADER_WMASK_EN
        , output cmd_mask_i
`endif
    );

    modport slave (
        input  cmd_v_i, cmd_w_i, cmd_bcast_i, cmd_core_i, cmd_reg_i, cmd_data_i, resp_yumi_i,
        output cmd_ready_o, resp_v_o, resp_data_o
`ifdef BP_CFG_LOADER_WMASK_EN
        , input cmd_mask_i
`endif
    );

endinterface

// File: rtl/bp_cfg_loader_bank.sv
// One core's bank of config registers: masked write port, combinational read port.
// Reg 0 (control) resets to 1 so the core starts frozen; all others reset to 0.
module bp_cfg_loader_bank
    import bp_cfg_loader_pkg::*;
#(
    parameter  int num_reg_p         = 8,
    parameter  int data_width_p      = 64,
    localparam int reg_addr_width_lp = `BSG_SAFE_CLOG2(num_reg_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              w_v_i,
    input  logic [reg_addr_width_lp-1:0]      w_reg_i,
    input  logic [data_width_p-1:0]           w_data_i,
    input  logic [data_width_p-1:0]           w_bitmask_i,
    input  logic [reg_addr_width_lp-1:0]      r_reg_i,
    output logic [data_width_p-1:0]           r_data_o,
    output logic [num_reg_p*data_width_p-1:0] regs_o
);

    for (genvar i = 0; i < num_reg_p; i++) begin : g_reg
        localparam logic [data_width_p-1:0] reset_val_lp =
            (i == e_cfg_ctrl_reg) ? data_width_p'(1) : '0;

        logic [data_width_p-1:0] reg_r;

        // register storage with bit-masked update
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                reg_r <= reset_val_lp;
            end else if (w_v_i && (w_reg_i == reg_addr_width_lp'(i))) begin
                reg_r <= (reg_r & ~w_bitmask_i) | (w_data_i & w_bitmask_i);
            end
        end

        assign regs_o[i*data_width_p +: data_width_p] = reg_r;
    end

    // read mux; an index with no matching register reads as zero
    always_comb begin
        r_data_o = '0;
        for (int i = 0; i < num_reg_p; i++) begin
            r_data_o = r_data_o
                     | ({data_width_p{r_reg_i == reg_addr_width_lp'(i)}}
                        & regs_o[i*data_width_p +: data_width_p]);
        end
    end

endmodule

// File: rtl/bp_cfg_loader.sv
// Runtime config register file: num_core_p banks, unicast/broadcast writes, single-outstanding reads.
// Optional byte-masked writes are enabled by defining BP_CFG_LOADER_WMASK_EN.
module bp_cfg_loader
    import bp_cfg_loader_pkg::*;
#(
    parameter  int num_core_p        = 4,
    parameter  int num_reg_p         = 8,
    parameter  int data_width_p      = 64,
    localparam int core_id_width_lp  = `BSG_SAFE_CLOG2(num_core_p),
    localparam int reg_addr_width_lp = `BSG_SAFE_CLOG2(num_reg_p)
) (
    input  logic                                         clk_i,
    input  logic                                         reset_i,
    bp_cfg_loader_if.slave                               cmd_if,
    output logic [num_core_p*num_reg_p*data_width_p-1:0] cfg_o,
    output logic [num_core_p-1:0]                        freeze_o
);

    localparam int bank_width_lp = num_reg_p * data_width_p;

    `BP_CFG_LOADER_CMD_S_DECLARE(core_id_width_lp, reg_addr_width_lp, data_width_p)

    bp_cfg_loader_cmd_s          cmd_s;
    bp_cfg_loader_state_e        state_r;
    logic [data_width_p-1:0]     resp_data_r;
    logic [data_width_p-1:0]     rd_data_s;
    logic [data_width_p-1:0]     bitmask_s;
    logic                        cmd_ready_s;
    logic                        fire_s;
    logic                        reg_ok_s;
    logic                        wr_s;
    logic                        rd_s;
    logic [core_id_width_lp-1:0] rd_core_s;
    logic [num_core_p-1:0]       bank_we_s;
    logic [data_width_p-1:0]     bank_rdata_s [num_core_p];

    assign cmd_s = '{w:       cmd_if.cmd_w_i,
                     bcast:   cmd_if.cmd_bcast_i,
                     core:    cmd_if.cmd_core_i,
                     reg_idx: cmd_if.cmd_reg_i,
                     data:    cmd_if.cmd_data_i};

    // A pending response may be retired and replaced by a new command in the same cycle
    assign cmd_ready_s = (state_r == e_ready) | ((state_r == e_resp) & cmd_if.resp_yumi_i);
    assign fire_s      = cmd_if.cmd_v_i & cmd_ready_s;
    assign reg_ok_s    = {1'b0, cmd_s.reg_idx} < (reg_addr_width_lp + 1)'(num_reg_p);
    assign wr_s        = fire_s & cmd_s.w & reg_ok_s;
    assign rd_s        = fire_s & ~cmd_s.w;
    assign rd_core_s   = cmd_s.bcast ? '0 : cmd_s.core;

`ifdef BP_CFG_LOADER_WMASK_EN
    // expand byte enables to a per-bit write mask
    always_comb begin
        bitmask_s = '0;
        for (int b = 0; b < data_width_p / 8; b++) begin
            bitmask_s[b*8 +: 8] = {8{cmd_if.cmd_mask_i[b]}};
        end
    end
`else
    assign bitmask_s = '1;
`endif

    // An out-of-range unicast core index matches no bank, so the write is dropped
    for (genvar n = 0; n < num_core_p; n++) begin : g_bank
        assign bank_we_s[n] = wr_s & (cmd_s.bcast | (cmd_s.core == core_id_width_lp'(n)));

        bp_cfg_loader_bank #(
            .num_reg_p    (num_reg_p),
            .data_width_p (data_width_p)
        ) bank (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .w_v_i       (bank_we_s[n]),
            .w_reg_i     (cmd_s.reg_idx),
            .w_data_i    (cmd_s.data),
            .w_bitmask_i (bitmask_s),
            .r_reg_i     (cmd_s.reg_idx),
            .r_data_o    (bank_rdata_s[n]),
            .regs_o      (cfg_o[n*bank_width_lp +: bank_width_lp])
        );

        assign freeze_o[n] = cfg_o[n*bank_width_lp + e_cfg_ctrl_reg*data_width_p + cfg_freeze_bit];
    end

    // bank select for reads; out-of-range core or register yields zero
    always_comb begin
        rd_data_s = '0;
        for (int n = 0; n < num_core_p; n++) begin
            rd_data_s = rd_data_s
                      | ({data_width_p{rd_core_s == core_id_width_lp'(n)}} & bank_rdata_s[n]);
        end
        rd_data_s = rd_data_s & {data_width_p{reg_ok_s}};
    end

    // response FSM and response data register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= e_ready;
            resp_data_r <= '0;
        end else begin
            case (state_r)
                e_ready: begin
                    if (rd_s) begin
                        state_r     <= e_resp;
                        resp_data_r <= rd_data_s;
                    end
                end
                e_resp: begin
                    if (cmd_if.resp_yumi_i) begin
                        if (rd_s) begin
                            resp_data_r <= rd_data_s;
                        end else begin
                            state_r <= e_ready;
                        end
                    end
                end
                default: begin
                    state_r <= e_ready;
                end
            endcase
        end
    end

    assign cmd_if.cmd_ready_o = cmd_ready_s;
    assign cmd_if.resp_v_o    = (state_r == e_resp);
    assign cmd_if.resp_data_o = resp_data_r;

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Directed bench for bp_cfg_loader: a 4x8x64 instance driven from a vector table plus
// hand-written sequences, and a 3x6x16 instance for out-of-range indices.
module tb_bp_cfg_loader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bp_cfg_loader_if #(.num_core_p(4), .num_reg_p(8), .data_width_p(64)) ia ();
    bp_cfg_loader_if #(.num_core_p(3), .num_reg_p(6), .data_width_p(16)) ib ();

    logic [2047:0] cfg_a;
    logic [3:0]    frz_a;
    logic [287:0]  cfg_b;
    logic [2:0]    frz_b;

    bp_cfg_loader #(.num_core_p(4), .num_reg_p(8), .data_width_p(64)) dut_a (
        .clk_i(clk), .reset_i(reset), .cmd_if(ia), .cfg_o(cfg_a), .freeze_o(frz_a));

    bp_cfg_loader #(.num_core_p(3), .num_reg_p(6), .data_width_p(16)) dut_b (
        .clk_i(clk), .reset_i(reset), .cmd_if(ib), .cfg_o(cfg_b), .freeze_o(frz_b));

    typedef struct {
        logic        w;
        logic        bcast;
        logic [1:0]  core;
        logic [2:0]  rg;
        logic [63:0] data;
        logic [63:0] exp_data;
        logic [3:0]  exp_freeze;
    } vec_t;

    vec_t vecs[16];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one command on port A; returns one cycle after it fires
    task automatic cmd_a(input logic w, input logic bc, input logic [1:0] core,
                         input logic [2:0] rg, input logic [63:0] data, input logic [7:0] mask);
        ia.cmd_v_i = 1'b1; ia.cmd_w_i = w; ia.cmd_bcast_i = bc;
        ia.cmd_core_i = core; ia.cmd_reg_i = rg; ia.cmd_data_i = data;
`ifdef BP_CFG_LOADER_WMASK_EN
        ia.cmd_mask_i = mask;
`endif
        tick();
        ia.cmd_v_i = 1'b0;
    endtask

    task automatic cmd_b(input logic w, input logic [1:0] core, input logic [2:0] rg,
                         input logic [15:0] data);
        ib.cmd_v_i = 1'b1; ib.cmd_w_i = w; ib.cmd_bcast_i = 1'b0;
        ib.cmd_core_i = core; ib.cmd_reg_i = rg; ib.cmd_data_i = data;
`ifdef BP_CFG_LOADER_WMASK_EN
        ib.cmd_mask_i = 2'b11;
`endif
        tick();
        ib.cmd_v_i = 1'b0;
    endtask

    task automatic read_a(input string name, input logic [1:0] core, input logic [2:0] rg,
                          input logic bc, input logic [63:0] exp);
        cmd_a(1'b0, bc, core, rg, 64'd0, 8'hFF);
        chk({name, "_v"}, 64'(ia.resp_v_o), 64'd1);
        chk({name, "_data"}, ia.resp_data_o, exp);
        ia.resp_yumi_i = 1'b1;
        tick();
        ia.resp_yumi_i = 1'b0;
        chk({name, "_done"}, 64'(ia.resp_v_o), 64'd0);
    endtask

    task automatic read_b(input string name, input logic [1:0] core, input logic [2:0] rg,
                          input logic [15:0] exp);
        cmd_b(1'b0, core, rg, 16'd0);
        chk({name, "_v"}, 64'(ib.resp_v_o), 64'd1);
        chk({name, "_data"}, 64'(ib.resp_data_o), 64'(exp));
        ib.resp_yumi_i = 1'b1;
        tick();
        ib.resp_yumi_i = 1'b0;
    endtask

    task automatic chk_reset_a();
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 8; r++)
                chk($sformatf("rst_cfg_a_c%0d_r%0d", c, r), cfg_a[(c*8+r)*64 +: 64],
                    (r == 0) ? 64'd1 : 64'd0);
        chk("rst_freeze_a", 64'(frz_a), 64'hF);
        chk("rst_resp_v_a", 64'(ia.resp_v_o), 64'd0);
        chk("rst_resp_data_a", ia.resp_data_o, 64'd0);
        chk("rst_ready_a", 64'(ia.cmd_ready_o), 64'd1);
    endtask

    task automatic chk_reset_b(input string name);
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 6; r++)
                chk($sformatf("%s_c%0d_r%0d", name, c, r), 64'(cfg_b[(c*6+r)*16 +: 16]),
                    (r == 0) ? 64'd1 : 64'd0);
    endtask

    initial begin
        ia.cmd_v_i = 1'b0; ia.cmd_w_i = 1'b0; ia.cmd_bcast_i = 1'b0; ia.cmd_core_i = '0;
        ia.cmd_reg_i = '0; ia.cmd_data_i = '0; ia.resp_yumi_i = 1'b0;
        ib.cmd_v_i = 1'b0; ib.cmd_w_i = 1'b0; ib.cmd_bcast_i = 1'b0; ib.cmd_core_i = '0;
        ib.cmd_reg_i = '0; ib.cmd_data_i = '0; ib.resp_yumi_i = 1'b0;
`ifdef BP_CFG_LOADER_WMASK_EN
        ia.cmd_mask_i = '1;
        ib.cmd_mask_i = '1;
`endif

        //          w     bcast core  reg   data                   exp_data               freeze
        vecs[0]  = '{1'b0, 1'b0, 2'd2, 3'd0, 64'd0,                 64'd1,                 4'hF};
        vecs[1]  = '{1'b1, 1'b0, 2'd2, 3'd0, 64'd0,                 64'd0,                 4'hB};
        vecs[2]  = '{1'b0, 1'b0, 2'd2, 3'd0, 64'd0,                 64'd0,                 4'hB};
        vecs[3]  = '{1'b1, 1'b1, 2'd0, 3'd5, 64'hDEAD_BEEF,         64'd0,                 4'hB};
        vecs[4]  = '{1'b0, 1'b0, 2'd0, 3'd5, 64'd0,                 64'hDEAD_BEEF,         4'hB};
        vecs[5]  = '{1'b0, 1'b0, 2'd3, 3'd5, 64'd0,                 64'hDEAD_BEEF,         4'hB};
        vecs[6]  = '{1'b0, 1'b1, 2'd3, 3'd5, 64'd0,                 64'hDEAD_BEEF,         4'hB};
        vecs[7]  = '{1'b1, 1'b0, 2'd1, 3'd3, 64'h0123456789ABCDEF, 64'd0,                 4'hB};
        vecs[8]  = '{1'b0, 1'b0, 2'd1, 3'd3, 64'd0,                 64'h0123456789ABCDEF, 4'hB};
        vecs[9]  = '{1'b0, 1'b0, 2'd0, 3'd3, 64'd0,                 64'd0,                 4'hB};
        vecs[10] = '{1'b1, 1'b1, 2'd0, 3'd0, 64'd1,                 64'd0,                 4'hF};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 3'd0, 64'd2,                 64'd0,                 4'hE};
        vecs[12] = '{1'b0, 1'b0, 2'd0, 3'd0, 64'd0,                 64'd2,                 4'hE};
        vecs[13] = '{1'b0, 1'b1, 2'd2, 3'd0, 64'd0,                 64'd2,                 4'hE};
        vecs[14] = '{1'b0, 1'b0, 2'd3, 3'd7, 64'd0,                 64'd0,                 4'hE};
        vecs[15] = '{1'b0, 1'b0, 2'd2, 3'd0, 64'd0,                 64'd1,                 4'hE};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_reset_a();
        chk("rst_freeze_b", 64'(frz_b), 64'h7);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].w) begin
                cmd_a(1'b1, vecs[i].bcast, vecs[i].core, vecs[i].rg, vecs[i].data, 8'hFF);
                chk($sformatf("vec%0d_wr_no_resp", i), 64'(ia.resp_v_o), 64'd0);
            end else begin
                read_a($sformatf("vec%0d_rd", i), vecs[i].core, vecs[i].rg, vecs[i].bcast,
                       vecs[i].exp_data);
            end
            chk($sformatf("vec%0d_freeze", i), 64'(frz_a), 64'(vecs[i].exp_freeze));
        end

        // full register image after the table
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 8; r++)
                chk($sformatf("img_c%0d_r%0d", c, r), cfg_a[(c*8+r)*64 +: 64],
                    (r == 5) ? 64'hDEAD_BEEF :
                    (c == 1 && r == 3) ? 64'h0123456789ABCDEF :
                    (r == 0) ? ((c == 0) ? 64'd2 : 64'd1) : 64'd0);

        // backpressure: response held for 3 cycles, then yumi plus a new read
        cmd_a(1'b0, 1'b0, 2'd1, 3'd3, 64'd0, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_hold%0d_v", k), 64'(ia.resp_v_o), 64'd1);
            chk($sformatf("bp_hold%0d_data", k), ia.resp_data_o, 64'h0123456789ABCDEF);
            chk($sformatf("bp_hold%0d_ready", k), 64'(ia.cmd_ready_o), 64'd0);
            tick();
        end
        ia.resp_yumi_i = 1'b1;
        ia.cmd_v_i = 1'b1; ia.cmd_w_i = 1'b0; ia.cmd_bcast_i = 1'b0;
        ia.cmd_core_i = 2'd0; ia.cmd_reg_i = 3'd5;
        #1;
        chk("b2b_ready", 64'(ia.cmd_ready_o), 64'd1);
        @(posedge clk);
        #1;
        ia.cmd_v_i = 1'b0; ia.resp_yumi_i = 1'b0;
        chk("b2b_v", 64'(ia.resp_v_o), 64'd1);
        chk("b2b_data", ia.resp_data_o, 64'hDEAD_BEEF);

        // write firing in the yumi cycle, then an immediate read of the same register
        ia.resp_yumi_i = 1'b1;
        cmd_a(1'b1, 1'b0, 2'd3, 3'd2, 64'h55, 8'hFF);
        ia.resp_yumi_i = 1'b0;
        chk("yumi_wr_v", 64'(ia.resp_v_o), 64'd0);
        chk("yumi_wr_ready", 64'(ia.cmd_ready_o), 64'd1);
        read_a("rd_after_wr", 2'd3, 3'd2, 1'b0, 64'h55);

`ifdef BP_CFG_LOADER_WMASK_EN
        cmd_a(1'b1, 1'b0, 2'd1, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        cmd_a(1'b1, 1'b0, 2'd1, 3'd1, 64'd0, 8'h0F);
        read_a("mask_0f", 2'd1, 3'd1, 1'b0, 64'hFFFF_FFFF_0000_0000);
        cmd_a(1'b1, 1'b0, 2'd1, 3'd1, 64'd0, 8'h00);
        read_a("mask_00", 2'd1, 3'd1, 1'b0, 64'hFFFF_FFFF_0000_0000);
`endif

        // out-of-range core and register on the 3-core, 6-register instance
        cmd_b(1'b1, 2'd3, 3'd0, 16'd0);
        chk("oor_core_freeze", 64'(frz_b), 64'h7);
        cmd_b(1'b1, 2'd1, 3'd6, 16'hABCD);
        cmd_b(1'b1, 2'd1, 3'd7, 16'h1234);
        chk_reset_b("oor_cfg_b");
        read_b("oor_core_rd", 2'd3, 3'd0, 16'd0);
        read_b("oor_reg_rd", 2'd1, 3'd7, 16'd0);
        read_b("b_c2_r0", 2'd2, 3'd0, 16'd1);
        cmd_b(1'b1, 2'd1, 3'd0, 16'd0);
        chk("b_freeze_c1", 64'(frz_b), 64'h5);
        read_b("b_c1_r0", 2'd1, 3'd0, 16'd0);

        // reset with a response pending
        cmd_a(1'b0, 1'b0, 2'd1, 3'd3, 64'd0, 8'hFF);
        chk("pre_rst_v", 64'(ia.resp_v_o), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_a();
        chk("rst_freeze_b2", 64'(frz_b), 64'h7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
